// File: rtl/ps2_pkg.sv
// Shared types and default prefix codes for the PS/2 key controller.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  typedef logic [7:0] scan_t;

  localparam scan_t BRK_CODE_DEF = 8'hF0;
  localparam scan_t EXT_CODE_DEF = 8'hE0;

endpackage

// File: rtl/ps2_code_decode.sv
// Scan-code decoder: prefix flags, make/break/repeat classification, held-key state.
// Optional key history register enabled by PS2_KEY_HIST_EN.
module ps2_code_decode
  import ps2_pkg::*;
#(
  parameter int    CNT_W    = 8,
  parameter scan_t BRK_CODE = BRK_CODE_DEF,
  parameter scan_t EXT_CODE = EXT_CODE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stb,
  input  scan_t            i_byte,
  output scan_t            o_cur_key,
  output logic             o_key_ext,
  output logic             o_key_down,
  output logic             o_key_valid,
  output logic [CNT_W-1:0] o_key_cnt
`ifdef PS2_KEY_HIST_EN
  ,
  output logic [23:0]      o_key_hist
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_brk_pend;
  logic             r_ext_pend;
  scan_t            r_cur_key;
  logic             r_key_ext;
  logic             r_key_down;
  logic             r_key_valid;
  logic [CNT_W-1:0] r_key_cnt;

  logic w_is_brk;
  logic w_is_ext;
  logic w_match;
  logic w_release;
  logic w_repeat;
  logic w_press;

  // A code matches the held key only if its extended-ness matches too.
  always_comb begin
    w_is_brk  = (i_byte == BRK_CODE);
    w_is_ext  = (i_byte == EXT_CODE);
    w_match   = (i_byte == r_cur_key) && (r_ext_pend == r_key_ext);
    w_release = !w_is_brk && !w_is_ext && r_brk_pend && w_match;
    w_repeat  = !w_is_brk && !w_is_ext && !r_brk_pend && r_key_down && w_match;
    w_press   = !w_is_brk && !w_is_ext && !r_brk_pend && !w_repeat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_brk_pend  <= 1'b0;
      r_ext_pend  <= 1'b0;
      r_cur_key   <= '0;
      r_key_ext   <= 1'b0;
      r_key_down  <= 1'b0;
      r_key_valid <= 1'b0;
      r_key_cnt   <= '0;
    end else begin
      r_key_valid <= 1'b0;
      if (i_stb) begin
        if (w_is_brk) begin
          r_brk_pend <= 1'b1;
        end else if (w_is_ext) begin
          r_ext_pend <= 1'b1;
        end else begin
          r_brk_pend <= 1'b0;
          r_ext_pend <= 1'b0;
          if (w_release) begin
            r_cur_key  <= '0;
            r_key_ext  <= 1'b0;
            r_key_down <= 1'b0;
          end else if (w_press) begin
            r_cur_key   <= i_byte;
            r_key_ext   <= r_ext_pend;
            r_key_down  <= 1'b1;
            r_key_valid <= 1'b1;
            r_key_cnt   <= r_key_cnt + CNT_ONE;
          end
        end
      end
    end
  end

`ifdef PS2_KEY_HIST_EN
  logic [23:0] r_key_hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_hist <= '0;
    end else if (i_stb && w_press) begin
      r_key_hist <= {r_key_hist[15:0], i_byte};
    end
  end

  assign o_key_hist = r_key_hist;
`endif

  assign o_cur_key   = r_cur_key;
  assign o_key_ext   = r_key_ext;
  assign o_key_down  = r_key_down;
  assign o_key_valid = r_key_valid;
  assign o_key_cnt   = r_key_cnt;

endmodule

// File: rtl/ps2_key_ctrl.sv
// Drains the ps2_keyboard FIFO (one byte per 3 cycles) and feeds the scan-code decoder.
// Define PS2_KEY_HIST_EN to add the key_hist output.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int    CNT_W    = 8,
  parameter scan_t BRK_CODE = BRK_CODE_DEF,
  parameter scan_t EXT_CODE = EXT_CODE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ps2_byte,
  input  logic             ps2_ready,
  input  logic             ps2_ovf,
  input  logic             ovf_clr,
  output logic             nextdata_n,
  output logic [7:0]       cur_key,
  output logic             key_ext,
  output logic             key_down,
  output logic             key_valid,
  output logic [CNT_W-1:0] key_cnt,
`ifdef PS2_KEY_HIST_EN
  output logic [23:0]      key_hist,
`endif
  output logic             ovf_sticky
);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_nextdata_n;
  scan_t  r_byte;
  logic   r_ovf_sticky;
  logic   w_stb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_nextdata_n <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_nextdata_n <= (w_state_nxt != ACK);
    end
  end

  // SETTLE gives the FIFO a cycle to advance its read pointer before ready is trusted again.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (ps2_ready) w_state_nxt = ACK;
      ACK:     w_state_nxt = SETTLE;
      SETTLE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && ps2_ready) begin
      r_byte <= ps2_byte;
    end
  end

  assign w_stb = (r_state == ACK);

  // Set has priority so an overflow in the clearing cycle is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf_sticky <= 1'b0;
    end else if (ps2_ovf) begin
      r_ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf_sticky <= 1'b0;
    end
  end

  ps2_code_decode #(
    .CNT_W    (CNT_W),
    .BRK_CODE (BRK_CODE),
    .EXT_CODE (EXT_CODE)
  ) u_decode (
    .clk         (clk),
    .rst         (rst),
    .i_stb       (w_stb),
    .i_byte      (r_byte),
    .o_cur_key   (cur_key),
    .o_key_ext   (key_ext),
    .o_key_down  (key_down),
    .o_key_valid (key_valid),
    .o_key_cnt   (key_cnt)
`ifdef PS2_KEY_HIST_EN
    ,
    .o_key_hist  (key_hist)
`endif
  );

  assign nextdata_n = r_nextdata_n;
  assign ovf_sticky = r_ovf_sticky;

endmodule
